// File: rtl/riscv_mmio_console.sv
// Memory-mapped console / test-status peripheral on the core data port.
// Byte stores to the TX register feed a FIFO drained over a valid/ready byte stream.
// The first full-word TOHOST store latches a sticky pass/fail result.
module riscv_mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    input  logic        d_we,
    input  logic        d_re,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RegTx     = 2'd0,
        RegStatus = 2'd1,
        RegTohost = 2'd2,
        RegRsvd   = 2'd3
    } reg_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [30:0]      fail_code_q, fail_code_d;

    logic sel;
    reg_e reg_idx;
    logic full, empty;
    logic tx_store, push, pop;

    assign sel      = (d_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx  = reg_e'(d_addr[3:2]);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_store = sel & d_we & (reg_idx == RegTx) & d_be[0];
    // Stall decision uses registered full, so a same-cycle pop cannot admit the store.
    assign push     = tx_store & ~full;
    assign pop      = ~empty & tx_ready;
    assign d_ready  = ~(tx_store & full);

    assign tx_valid  = ~empty;
    assign tx_data   = mem_q[rd_ptr_q];
    assign d_rdata   = rdata_q;
    assign d_rvalid  = rvalid_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;

    // Next-state for FIFO pointers, load response and TOHOST status.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        rvalid_d    = sel & d_re;
        rdata_d     = rdata_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;

        // STATUS reflects occupancy before this cycle's push/pop.
        if (sel && d_re) begin
            unique case (reg_idx)
                RegTx:     rdata_d = 32'h0;
                RegStatus: rdata_d = {14'h0, empty, full, 16'(count_q)};
                RegTohost: rdata_d = {pass_q, fail_code_q};
                RegRsvd:   rdata_d = 32'h0;
            endcase
        end

        if (sel && d_we && (reg_idx == RegTohost) && (d_be == 4'hF) && !done_q) begin
            done_d      = 1'b1;
            pass_d      = (d_wdata == 32'd1);
            fail_code_d = (d_wdata == 32'd1) ? 31'h0 : d_wdata[31:1];
        end
    end

    // Control and status state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= 32'h0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= 31'h0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
        end
    end

    // FIFO storage; contents are don't-care while their slot is not occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= d_wdata[7:0];
        end
    end

endmodule
